dmem_responder: RTL
===================

Name: dmem_responder

Overview:
Data-memory responder on the far side of the MEM-stage load/store interface. It accepts one request at a time from the pipeline using a valid/ready handshake. Each request takes a fixed, configurable access latency. Loads are size-formatted and sign/zero-extended, so the returned word can go straight into the MEM/WB mem_data input.

Parameters:
ADDR_WIDTH, 10, word-address bits; array depth is 2**ADDR_WIDTH 32-bit words (4 KiB at default)
LATENCY, 2, cycles from request acceptance to first rsp_valid cycle; legal range 1..15

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_we  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  zero-extend load result (LBU/LHU)
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  response present
rsp_ready  in  1  pipeline accepts response
rsp_rdata  out  32  formatted load data; 0 for stores and errors
rsp_err  out  1  misaligned, illegal size, or out-of-range access

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0.
- Reset does not clear the memory array.
- Reset mid-transaction discards the pending request. A store not yet committed is never written.
- Only one request is outstanding at a time. There is no request pipelining.
- States: IDLE, WAIT, RESP. req_ready=1 only in IDLE.
- IDLE: on req_valid & req_ready, capture we/addr/size/unsigned/wdata.
  - LATENCY=1: go to RESP.
  - Otherwise: load counter with LATENCY-2 and go to WAIT.
- WAIT: decrement the counter each cycle; at 0, go to RESP.
- Access point: the array read or write happens on the clock edge that enters RESP. The captured request is checked there:
  - err when size=11.
  - err when size=01 and addr[0]=1.
  - err when size=10 and addr[1:0]!=0.
  - err when addr[31:ADDR_WIDTH+2]!=0.
  - On err: no write, rsp_rdata=0, rsp_err=1.
- Store: word index addr[ADDR_WIDTH+1:2].
  - byte: lane addr[1:0] gets wdata[7:0].
  - half: lanes addr[1]*2 and addr[1]*2+1 get wdata[15:0].
  - word: all four lanes.
  - Other lanes are unchanged. rsp_rdata=0.
- Load: select the byte or half by addr[1:0]/addr[1]. Sign-extend from bit 7 or 15 unless req_unsigned. req_unsigned is ignored for word loads.
- RESP: rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready. On rsp_valid & rsp_ready, go to IDLE and clear rsp_valid.
  - Result: at most one request accepted per LATENCY+1 cycles.
- Simultaneous events: in RESP, req_valid is ignored because req_ready=0. A request arriving the cycle after the response is accepted is accepted normally.
- Response latency is exactly LATENCY cycles from the acceptance edge to rsp_valid.
- A store followed by a load to the same address returns the new data (sequential, no hazard).

Optional Feature:
DMEM_STATS_EN
- Defined: adds outputs stat_loads, stat_stores, stat_errs (32-bit each).
  - Each increments on the access-point edge of the matching completed access.
  - Erroring accesses count only in stat_errs.
  - Each counter saturates at 0xFFFFFFFF.
  - All are cleared by reset_n.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package dmem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL.
  - state enum ST_IDLE/ST_WAIT/ST_RESP.
  - function computing the misalignment flag.
- One sub-module: dmem_load_align, combinational. Inputs: raw word, addr[1:0], size, unsigned. Output: formatted rdata.
- The store byte-lane merge stays inline.

Test Plan:
1. Reset, then store word 0xDEADBEEF @0x10, LATENCY=2, rsp_ready=1 -> rsp_valid exactly 2 cycles after acceptance, rsp_err=0, rsp_rdata=0. Next load word @0x10 -> 0xDEADBEEF.
2. Memory @0x20=0x80FF7F01 -> load byte signed @0x23 gives 0xFFFFFF80. LBU @0x23 gives 0x00000080. Load half signed @0x22 gives 0xFFFF80FF. Load byte @0x20 gives 0x00000001.
3. Store byte 0xAB @0x21 over 0x11223344 -> load word @0x20 gives 0x1122AB44. Store half 0xCAFE @0x22 -> 0xCAFEAB44.
4. Misaligned word load @0x06, half store @0x03, size=11, addr=0x00001000 at ADDR_WIDTH=10:
   - each gives rsp_err=1, rsp_rdata=0.
   - array unchanged (verified by a later read).
5. Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable and req_ready=0 throughout. Raise rsp_ready -> IDLE the next cycle. A second request is accepted in IDLE.
6. Drop reset_n during WAIT of a store 0x55 @0x40 -> outputs at reset values immediately; load @0x40 afterwards returns the old contents. With DMEM_STATS_EN, scenarios 1–4 give stat_loads/stat_stores/stat_errs equal to the counts issued.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory responder.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
      return ((size == SZ_HALF) && a[0]) || ((size == SZ_WORD) && (a != 2'b00));
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load formatter: picks the addressed byte/half out of a word and sign/zero-extends it.
module dmem_load_align
   import dmem_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  addr_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   output logic [31:0] rdata_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word_i[{addr_i, 3'b000} +: 8];
      half_sel = word_i[{addr_i[1], 4'b0000} +: 16];
      case (size_i)
         SZ_BYTE: rdata_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
         SZ_HALF: rdata_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
         default: rdata_o = word_i;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed access latency.
// Optional statistics counters are enabled by defining DMEM_STATS_EN.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
`ifdef DMEM_STATS_EN
   ,
   output logic [31:0] stat_loads,
   output logic [31:0] stat_stores,
   output logic [31:0] stat_errs
`endif
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        cap_we_q, cap_uns_q;
   logic [31:0] cap_addr_q, cap_wdata_q;
   logic [1:0]  cap_size_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic [31:0] mem [DEPTH];

   logic        accept;
   logic        acc_go, acc_we, acc_uns, acc_err;
   logic [31:0] acc_addr, acc_wdata;
   logic [1:0]  acc_size;
   logic [ADDR_WIDTH-1:0] idx;
   logic [31:0] raw, ld_data, wmerge;

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign accept    = req_valid & req_ready;

   // With LATENCY=1 the access point is the acceptance edge, so use the live request.
   always_comb begin
      if (LATENCY == 1) begin
         acc_go    = accept;
         acc_we    = req_we;
         acc_addr  = req_addr;
         acc_size  = req_size;
         acc_uns   = req_unsigned;
         acc_wdata = req_wdata;
      end else begin
         acc_go    = (state_q == ST_WAIT) && (cnt_q == 4'd0);
         acc_we    = cap_we_q;
         acc_addr  = cap_addr_q;
         acc_size  = cap_size_q;
         acc_uns   = cap_uns_q;
         acc_wdata = cap_wdata_q;
      end
   end

   assign acc_err = (acc_size == SZ_ILL) || misaligned(acc_size, acc_addr[1:0]) ||
                    ((acc_addr >> (ADDR_WIDTH + 2)) != 32'd0);
   assign idx     = acc_addr[ADDR_WIDTH+1:2];
   assign raw     = mem[idx];

   dmem_load_align u_align (
      .word_i     (raw),
      .addr_i     (acc_addr[1:0]),
      .size_i     (acc_size),
      .unsigned_i (acc_uns),
      .rdata_o    (ld_data)
   );

   always_comb begin
      wmerge = raw;
      case (acc_size)
         SZ_BYTE: wmerge[{acc_addr[1:0], 3'b000} +: 8]  = acc_wdata[7:0];
         SZ_HALF: wmerge[{acc_addr[1], 4'b0000} +: 16] = acc_wdata[15:0];
         default: wmerge = acc_wdata;
      endcase
   end

   // Array is deliberately outside reset; reset_n gates the write so a held reset never commits.
   always_ff @(posedge clk) begin
      if (reset_n && acc_go && acc_we && !acc_err) mem[idx] <= wmerge;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: if (accept) begin
            if (LATENCY == 1) state_d = ST_RESP;
            else begin
               state_d = ST_WAIT;
               cnt_d   = 4'(LATENCY - 2);
            end
         end
         ST_WAIT: if (cnt_q == 4'd0) state_d = ST_RESP;
                  else cnt_d = cnt_q - 4'd1;
         ST_RESP: if (rsp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         cap_we_q    <= 1'b0;
         cap_addr_q  <= 32'd0;
         cap_size_q  <= SZ_BYTE;
         cap_uns_q   <= 1'b0;
         cap_wdata_q <= 32'd0;
         rdata_q     <= 32'd0;
         err_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            cap_we_q    <= req_we;
            cap_addr_q  <= req_addr;
            cap_size_q  <= req_size;
            cap_uns_q   <= req_unsigned;
            cap_wdata_q <= req_wdata;
         end
         if (acc_go) begin
            err_q   <= acc_err;
            rdata_q <= (acc_err || acc_we) ? 32'd0 : ld_data;
         end
      end
   end

`ifdef DMEM_STATS_EN
   logic [31:0] st_ld_q, st_st_q, st_er_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st_ld_q <= 32'd0;
         st_st_q <= 32'd0;
         st_er_q <= 32'd0;
      end else if (acc_go) begin
         if (acc_err)     st_er_q <= sat_inc(st_er_q);
         else if (acc_we) st_st_q <= sat_inc(st_st_q);
         else             st_ld_q <= sat_inc(st_ld_q);
      end
   end

   assign stat_loads  = st_ld_q;
   assign stat_stores = st_st_q;
   assign stat_errs   = st_er_q;
`endif

endmodule
